// File: rtl/sprite_pkg.sv
// Shared constants, attribute-word field positions and types for the sprite scanline engine.
package sprite_pkg;
  localparam int unsigned NUM_ENTRIES  = 8;
  localparam int unsigned MAX_PER_LINE = 4;
  localparam int unsigned SPRITE_SIZE  = 16;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned PIX_W   = 4;
  localparam int unsigned TILE_W  = 3;
  localparam int unsigned ROM_W   = 2 * TILE_W + 2 * PIX_W;
  localparam int unsigned ATTR_W  = 32;

  localparam int unsigned ATTR_EN      = 31;
  localparam int unsigned ATTR_RSV_MSB = 30;
  localparam int unsigned ATTR_RSV_LSB = 26;
  localparam int unsigned ATTR_X_MSB   = 25;
  localparam int unsigned ATTR_X_LSB   = 16;
  localparam int unsigned ATTR_Y_MSB   = 15;
  localparam int unsigned ATTR_Y_LSB   = 6;
  localparam int unsigned ATTR_ROW_MSB = 5;
  localparam int unsigned ATTR_ROW_LSB = 3;
  localparam int unsigned ATTR_COL_MSB = 2;
  localparam int unsigned ATTR_COL_LSB = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic               valid;
    logic [COORD_W-1:0] x;
    logic [TILE_W-1:0]  row;
    logic [TILE_W-1:0]  col;
    logic [PIX_W-1:0]   dy;
  } slot_t;
endpackage

// File: rtl/sprite_slot_match.sv
// Horizontal hit test for one retained sprite slot; combinational.
module sprite_slot_match
  import sprite_pkg::*;
#(
  parameter int unsigned SIZE = SPRITE_SIZE
) (
  input  slot_t              slot,
  input  logic [COORD_W-1:0] hcount,
  input  logic               video_on,
  output logic               match_c,
  output logic [PIX_W-1:0]   px_c
);
  localparam logic [COORD_W-1:0] SIZE_V = COORD_W'(SIZE);

  logic [COORD_W-1:0] dx;

  // hcount >= x keeps a sprite near x=1023 from wrapping onto low pixels
  assign dx      = hcount - slot.x;
  assign match_c = slot.valid && video_on && (hcount >= slot.x) && (dx < SIZE_V);
  assign px_c    = dx[PIX_W-1:0];
endmodule

// File: rtl/sprite_scan.sv
// Per-scanline sprite evaluation: fetches attribute RAM during blanking into a few slots,
// then resolves the winning sprite pixel each cycle of the active line.
module sprite_scan #(
  parameter int unsigned NUM_ENTRIES  = sprite_pkg::NUM_ENTRIES,
  parameter int unsigned MAX_PER_LINE = sprite_pkg::MAX_PER_LINE,
  parameter int unsigned SPRITE_SIZE  = sprite_pkg::SPRITE_SIZE
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             line_start,
  input  logic [sprite_pkg::COORD_W-1:0]   vcount,
  input  logic [sprite_pkg::COORD_W-1:0]   hcount,
  input  logic                             video_on,
  output logic [$clog2(NUM_ENTRIES)-1:0]   addrb,
  input  logic [sprite_pkg::ATTR_W-1:0]    doutb,
  output logic [sprite_pkg::ROM_W-1:0]     rom_addr,
  output logic                             sprite_on,
  output logic                             busy,
  output logic                             overflow
);
  import sprite_pkg::*;

  localparam int unsigned ADDR_W = $clog2(NUM_ENTRIES);
  localparam int unsigned CNT_W  = $clog2(MAX_PER_LINE + 1);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(NUM_ENTRIES - 1);
  localparam logic [CNT_W-1:0]   FULL      = CNT_W'(MAX_PER_LINE);
  localparam logic [COORD_W-1:0] SIZE_V    = COORD_W'(SPRITE_SIZE);

  state_t state, state_nx;
  logic                    rd_pend;
  logic [COORD_W-1:0]      vline;
  logic [COORD_W-1:0]      attr_y_c;
  logic [COORD_W-1:0]      dy_c;
  logic                    vhit_c;
  logic [CNT_W-1:0]        fill;
  slot_t                   slots [MAX_PER_LINE];
  slot_t                   new_slot_c;
  logic [MAX_PER_LINE-1:0] match_c;
  logic [PIX_W-1:0]        px_c [MAX_PER_LINE];
  logic                    any_c;
  logic [ROM_W-1:0]        win_addr_c;
  logic                    unused_attr;

  assign unused_attr = ^doutb[ATTR_RSV_MSB:ATTR_RSV_LSB];

  // Vertical test on the word returned for the previous address; no wrap past line 1023
  assign attr_y_c = doutb[ATTR_Y_MSB:ATTR_Y_LSB];
  assign dy_c     = vline - attr_y_c;
  assign vhit_c   = rd_pend && doutb[ATTR_EN] && (vline >= attr_y_c) && (dy_c < SIZE_V);

  assign new_slot_c = '{valid: 1'b1,
                        x:     doutb[ATTR_X_MSB:ATTR_X_LSB],
                        row:   doutb[ATTR_ROW_MSB:ATTR_ROW_LSB],
                        col:   doutb[ATTR_COL_MSB:ATTR_COL_LSB],
                        dy:    dy_c[PIX_W-1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (line_start) begin
      state_nx = FETCH;
    end else begin
      case (state)
        FETCH:   if (addrb == LAST_ADDR) state_nx = DRAIN;
        DRAIN:   state_nx = IDLE;
        default: state_nx = state;
      endcase
    end
  end

  // Address sequencing and slot fill; rd_pend marks cycles where doutb holds a fetched word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addrb    <= '0;
      rd_pend  <= 1'b0;
      vline    <= '0;
      fill     <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      for (int k = 0; k < int'(MAX_PER_LINE); k++) slots[k] <= '0;
    end else begin
      busy <= (state_nx != IDLE);
      if (line_start) begin
        vline    <= vcount;
        addrb    <= '0;
        rd_pend  <= 1'b0;
        fill     <= '0;
        overflow <= 1'b0;
        for (int k = 0; k < int'(MAX_PER_LINE); k++) slots[k] <= '0;
      end else begin
        rd_pend <= (state == FETCH);
        if (state == FETCH && addrb != LAST_ADDR) addrb <= addrb + ADDR_W'(1);
        if (vhit_c) begin
          if (fill == FULL) begin
            overflow <= 1'b1;
          end else begin
            for (int k = 0; k < int'(MAX_PER_LINE); k++)
              if (fill == CNT_W'(k)) slots[k] <= new_slot_c;
            fill <= fill + CNT_W'(1);
          end
        end
      end
    end
  end

  for (genvar k = 0; k < int'(MAX_PER_LINE); k++) begin : g_match
    sprite_slot_match #(.SIZE(SPRITE_SIZE)) u_match (
      .slot     (slots[k]),
      .hcount   (hcount),
      .video_on (video_on),
      .match_c  (match_c[k]),
      .px_c     (px_c[k])
    );
  end

  // Lowest slot index (earliest attribute address) wins
  always_comb begin
    any_c      = |match_c;
    win_addr_c = rom_addr;
    for (int k = int'(MAX_PER_LINE) - 1; k >= 0; k--)
      if (match_c[k]) win_addr_c = {slots[k].row, slots[k].col, slots[k].dy, px_c[k]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sprite_on <= 1'b0;
      rom_addr  <= '0;
    end else begin
      sprite_on <= any_c;
      if (any_c) rom_addr <= win_addr_c;
    end
  end
endmodule

// File: tb/tb_sprite_scan.sv
// Randomized scoreboard bench for sprite_scan against a list-based scanline model.
module tb_sprite_scan;
  logic        clk = 1'b0;
  logic        reset;
  logic        line_start;
  logic [9:0]  vcount;
  logic [9:0]  hcount;
  logic        video_on;
  logic [2:0]  addrb;
  logic [31:0] doutb;
  logic [13:0] rom_addr;
  logic        sprite_on;
  logic        busy;
  logic        overflow;

  sprite_scan dut (
    .clk        (clk),
    .reset      (reset),
    .line_start (line_start),
    .vcount     (vcount),
    .hcount     (hcount),
    .video_on   (video_on),
    .addrb      (addrb),
    .doutb      (doutb),
    .rom_addr   (rom_addr),
    .sprite_on  (sprite_on),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [8];
  always @(posedge clk) doutb <= mem[addrb];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Model: sprites retained for the current line, in attribute-address order
  int m_n;
  bit m_ovf;
  int m_x [4];
  int m_row [4];
  int m_col [4];
  int m_dy [4];
  int rom_prev;

  typedef struct {
    int due;
    bit on;
    int rom;
  } exp_t;
  exp_t sbq [$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0 && sbq[0].due < cyc) begin
      mon_e = sbq.pop_front();
      checks++;
      errors++;
      $display("FAIL stale_expect: due %0d now %0d", mon_e.due, cyc);
    end else if (sbq.size() > 0 && sbq[0].due == cyc) begin
      mon_e = sbq.pop_front();
      chk("sprite_on", 32'(sprite_on), 32'(mon_e.on));
      chk("rom_addr", 32'(rom_addr), 32'(mon_e.rom));
    end
  end

  function automatic logic [31:0] mk(input bit en, input int rsv, input int x, input int y,
                                     input int row, input int col);
    return {en, 5'(rsv), 10'(x), 10'(y), 3'(row), 3'(col)};
  endfunction

  task automatic clear_mem();
    for (int a = 0; a < 8; a++) mem[a] = 32'h0;
  endtask

  task automatic set_line(input int v);
    int y;
    m_n   = 0;
    m_ovf = 0;
    for (int a = 0; a < 8; a++) begin
      y = int'(mem[a][15:6]);
      if (mem[a][31] && v >= y && v - y < 16) begin
        if (m_n < 4) begin
          m_x[m_n]   = int'(mem[a][25:16]);
          m_row[m_n] = int'(mem[a][5:3]);
          m_col[m_n] = int'(mem[a][2:0]);
          m_dy[m_n]  = v - y;
          m_n++;
        end else begin
          m_ovf = 1;
        end
      end
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1
  task automatic px(input int h, input bit vo);
    int hit;
    hit = -1;
    hcount   = 10'(h);
    video_on = vo;
    if (vo)
      for (int k = 0; k < m_n; k++)
        if (hit < 0 && h >= m_x[k] && h - m_x[k] < 16) hit = k;
    if (hit >= 0)
      rom_prev = m_row[hit] * 2048 + m_col[hit] * 256 + m_dy[hit] * 16 + (h - m_x[hit]);
    sbq.push_back('{due: cyc + 1, on: (hit >= 0), rom: rom_prev});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    px(0, 0);
    for (int i = 0; i < 4 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d expectations left", sbq.size());
      sbq.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_line(input int v);
    set_line(v);
    line_start = 1'b1;
    vcount     = 10'(v);
    @(posedge clk);
    #1;
    line_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("fetch_addrb", 32'(addrb), 32'(i));
      chk("fetch_busy", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
    end
    chk("drain_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v, y, h;
    reset = 1'b0; line_start = 1'b0; vcount = '0; hcount = '0; video_on = 1'b0;
    rom_prev = 0; m_n = 0; m_ovf = 0;
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sprite_on", 32'(sprite_on), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_addrb", 32'(addrb), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Single sprite, known ROM address
    mem[0] = 32'h80501008;
    do_line(70);
    px(85, 1);
    chk("basic_on", 32'(sprite_on), 32'd1);
    chk("basic_rom", 32'(rom_addr), 32'h865);
    drain();

    // Line just below the sprite: nothing across the whole active width
    do_line(80);
    for (int i = 0; i < 640; i++) px(i, 1);
    drain();

    // Six sprites on one line: four kept, overflow set
    clear_mem();
    for (int a = 0; a < 6; a++) mem[a] = mk(1, 0, 40 * a + 20, 100, a, (a + 1) % 8);
    do_line(105);
    chk("ovf_six", 32'(overflow), 32'd1);
    for (int a = 0; a < 6; a++) px(40 * a + 23, 1);
    drain();

    // Overlapping sprites: lower address wins
    clear_mem();
    mem[2] = mk(1, 0, 200, 100, 2, 3);
    mem[5] = mk(1, 0, 200, 98, 6, 7);
    do_line(105);
    chk("prio_ovf", 32'(overflow), 32'd0);
    px(205, 1);
    chk("prio_rom", 32'(rom_addr), 32'h1355);
    px(215, 1);
    px(216, 1);
    drain();

    // Edge of coordinate space, disabled entry
    clear_mem();
    mem[0] = mk(1, 0, 1020, 1020, 1, 1);
    mem[1] = mk(0, 0, 50, 100, 4, 4);
    do_line(3);
    for (int i = 1016; i < 1024; i++) px(i, 1);
    for (int i = 0; i < 6; i++) px(i, 1);
    drain();
    do_line(1023);
    px(1023, 1);
    chk("edge_on", 32'(sprite_on), 32'd1);
    px(2, 1);
    chk("edge_nowrap", 32'(sprite_on), 32'd0);
    px(1020, 1);
    drain();
    do_line(100);
    px(55, 1);
    chk("disabled_on", 32'(sprite_on), 32'd0);
    drain();

    // Reset mid-fetch, then a full fetch
    clear_mem();
    for (int a = 0; a < 8; a++) mem[a] = mk(1, 31, 100 * a, 200, 7 - a, a);
    line_start = 1'b1;
    vcount     = 10'd200;
    @(posedge clk);
    #1;
    line_start = 1'b0;
    for (int i = 0; i < 12 && addrb != 3'd4; i++) begin
      @(posedge clk);
      #1;
    end
    chk("mid_addrb", 32'(addrb), 32'd4);
    #2;
    reset = 1'b0;
    #1;
    chk("async_sprite_on", 32'(sprite_on), 32'd0);
    chk("async_rom_addr", 32'(rom_addr), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_overflow", 32'(overflow), 32'd0);
    chk("async_addrb", 32'(addrb), 32'd0);
    rom_prev = 0;
    m_n = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_addrb", 32'(addrb), 32'd0);
    do_line(205);
    for (int a = 0; a < 8; a++) px(100 * a + 1, 1);
    drain();

    // Randomized lines
    for (int l = 0; l < 25; l++) begin
      v = int'($urandom_range(0, 1023));
      for (int a = 0; a < 8; a++) begin
        if ($urandom_range(0, 9) < 7) y = (v - int'($urandom_range(0, 22))) & 1023;
        else y = int'($urandom_range(0, 1023));
        mem[a] = mk($urandom_range(0, 9) < 8, int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 1023)), y,
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      end
      do_line(v);
      for (int p = 0; p < 120; p++) begin
        if ($urandom_range(0, 9) < 6)
          h = (int'(mem[$urandom_range(0, 7)][25:16]) + int'($urandom_range(0, 20)) - 2) & 1023;
        else
          h = int'($urandom_range(0, 1023));
        px(h, $urandom_range(0, 9) < 8);
      end
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
